// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if
// Bundles the request/transfer inputs and the grant/owner outputs of the
// round-robin AHB arbiter.
//   master_req_in       per-master bus request (HBUSREQ)
//   master_lock_in      per-master lock request (HLOCK)
//   bus_trans_in        HTRANS of the address-phase owner
//   bus_burst_in        HBURST of the address-phase owner
//   bus_ready_in        HREADY
//   master_grant_out    one-hot grant (HGRANT)
//   bus_master_out      address-phase owner index (HMASTER)
//   bus_master_data_out data-phase owner index
//   bus_mastlock_out    HMASTLOCK
// Modports: slave = arbiter side, master = fabric/masters side.
interface ahb_arbiter_if #(
    parameter int MASTERS = 4
);
    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] master_req_in;
    logic [MASTERS-1:0] master_lock_in;
    logic [1:0]         bus_trans_in;
    logic [2:0]         bus_burst_in;
    logic               bus_ready_in;
    logic [MASTERS-1:0] master_grant_out;
    logic [IW-1:0]      bus_master_out;
    logic [IW-1:0]      bus_master_data_out;
    logic               bus_mastlock_out;

    modport slave (
        input  master_req_in, master_lock_in, bus_trans_in, bus_burst_in, bus_ready_in,
        output master_grant_out, bus_master_out, bus_master_data_out, bus_mastlock_out
    );

    modport master (
        output master_req_in, master_lock_in, bus_trans_in, bus_burst_in, bus_ready_in,
        input  master_grant_out, bus_master_out, bus_master_data_out, bus_mastlock_out
    );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
// Round-robin AHB bus arbiter. Grants the shared address/control bus to one
// of MASTERS masters, changing ownership only at legal transfer boundaries
// (single transfers, end of fixed-length bursts, owner idle or not requesting).
// Publishes registered address-phase and data-phase owner indices.
// Ports:
//   bus_clk_in   bus clock, rising edge
//   bus_rst_in   asynchronous reset, active-high
//   bus          ahb_arbiter_if.slave (requests, HTRANS/HBURST/HREADY in;
//                grant, owners, mastlock out)
// Optional feature macro: AHB_ARBITER_LOCK_EN enables locked sequences
// (LOCK state, HMASTLOCK). Without it lock requests are ignored and
// bus_mastlock_out is 0.
//
// state | meaning
// PARK  | nobody requesting, default master granted
// OWN   | master granted, no fixed-length burst in progress
// BURST | fixed-length burst in progress, never pre-empted
// LOCK  | locked sequence in progress (AHB_ARBITER_LOCK_EN only)
module ahb_arbiter #(
    parameter int MASTERS        = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic         bus_clk_in,
    input  logic         bus_rst_in,
    ahb_arbiter_if.slave bus
);
    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam logic [MASTERS-1:0] GRANT_RST = {{(MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

`ifdef AHB_ARBITER_LOCK_EN
    typedef enum logic [1:0] {PARK = 2'd0, OWN = 2'd1, BURST = 2'd2, LOCK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {PARK = 2'd0, OWN = 2'd1, BURST = 2'd2} state_t;
`endif

    state_t             r_state, w_state_n, w_eff;
    logic [MASTERS-1:0] r_grant, w_grant_n;
    logic [IW-1:0]      r_ptr, w_ptr_n;
    logic [IW-1:0]      r_owner, r_data_owner, w_gidx;
    logic [3:0]         r_cnt, w_cnt_n, w_len;
    logic               r_mastlock;

    logic               w_found, w_handover, w_own_req, w_own_hand;
    logic               w_idle, w_nonseq, w_seq;
    logic [IW-1:0]      w_winner;
    int                 w_best, w_dist;

    assign w_idle    = (bus.bus_trans_in == 2'b00);
    assign w_nonseq  = (bus.bus_trans_in == 2'b10);
    assign w_seq     = (bus.bus_trans_in == 2'b11);
    assign w_own_req = |(bus.master_req_in & r_grant);

`ifdef AHB_ARBITER_LOCK_EN
    logic w_own_lock, w_lock_entry;
    assign w_own_lock   = |(bus.master_lock_in & r_grant);
    assign w_lock_entry = w_nonseq && w_own_lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = |bus.master_lock_in;
`endif

    // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
    always_comb begin
        w_len = 4'd0;
        case (bus.bus_burst_in)
            3'b010, 3'b011: w_len = 4'd3;
            3'b100, 3'b101: w_len = 4'd7;
            3'b110, 3'b111: w_len = 4'd15;
            default:        w_len = 4'd0;
        endcase
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (r_grant[i]) w_gidx = IW'(i);
        end
    end

    // Round-robin search: distance 0 is pointer+1, the pointer itself is last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = IW'(DEFAULT_MASTER);
        w_best   = MASTERS;
        w_dist   = 0;
        for (int i = 0; i < MASTERS; i++) begin
            w_dist = (i + 2 * MASTERS - 1 - int'(r_ptr)) % MASTERS;
            if (bus.master_req_in[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = IW'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_eff = r_state;
`ifdef AHB_ARBITER_LOCK_EN
        // Once the lock drops, the sequence falls back to normal burst tracking.
        if (r_state == LOCK && !w_own_lock) w_eff = (r_cnt != 4'd0) ? BURST : OWN;
`endif
        w_own_hand = w_idle || !w_own_req || (w_nonseq && bus.bus_burst_in == 3'b000);
`ifdef AHB_ARBITER_LOCK_EN
        w_own_hand = w_own_hand && !w_lock_entry;
`endif
        w_handover = 1'b0;
        case (w_eff)
            PARK:    w_handover = bus.bus_ready_in;
            OWN:     w_handover = bus.bus_ready_in && w_own_hand;
            BURST:   w_handover = bus.bus_ready_in && w_seq && (r_cnt == 4'd1);
            default: w_handover = 1'b0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_grant_n = r_grant;
        w_ptr_n   = r_ptr;
        if (w_handover) begin
            w_cnt_n   = 4'd0;
            w_state_n = w_found ? OWN : PARK;
            w_grant_n = {{(MASTERS-1){1'b0}}, 1'b1} << w_winner;
            w_ptr_n   = w_winner;
        end else if (bus.bus_ready_in) begin
            w_state_n = w_eff;
            if (w_nonseq && w_len != 4'd0)  w_cnt_n = w_len;
            else if (w_seq && r_cnt != 4'd0) w_cnt_n = r_cnt - 4'd1;
            case (w_eff)
                OWN: begin
                    if (w_nonseq && w_len != 4'd0) w_state_n = BURST;
`ifdef AHB_ARBITER_LOCK_EN
                    if (w_lock_entry) w_state_n = LOCK;
`endif
                end
                BURST:   if (w_cnt_n == 4'd0) w_state_n = OWN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge bus_clk_in or posedge bus_rst_in) begin
        if (bus_rst_in) begin
            r_state      <= PARK;
            r_grant      <= GRANT_RST;
            r_ptr        <= IW'(DEFAULT_MASTER);
            r_cnt        <= 4'd0;
            r_owner      <= IW'(DEFAULT_MASTER);
            r_data_owner <= IW'(DEFAULT_MASTER);
            r_mastlock   <= 1'b0;
        end else if (bus.bus_ready_in) begin
            r_state      <= w_state_n;
            r_grant      <= w_grant_n;
            r_ptr        <= w_ptr_n;
            r_cnt        <= w_cnt_n;
            r_owner      <= w_gidx;
            r_data_owner <= r_owner;
`ifdef AHB_ARBITER_LOCK_EN
            r_mastlock   <= w_own_lock;
`else
            r_mastlock   <= 1'b0;
`endif
        end
    end

    assign bus.master_grant_out    = r_grant;
    assign bus.bus_master_out      = r_owner;
    assign bus.bus_master_data_out = r_data_owner;
    assign bus.bus_mastlock_out    = r_mastlock;
endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    ahb_arbiter_if #(.MASTERS(4)) bus_if ();

    ahb_arbiter #(.MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .bus_clk_in (clk),
        .bus_rst_in (rst),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.master_req_in  = 4'b0000;
        bus_if.master_lock_in = 4'b0000;
        bus_if.bus_trans_in   = 2'b00;
        bus_if.bus_burst_in   = 3'b000;
        bus_if.bus_ready_in   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_grant: got %b expected 0001", bus_if.master_grant_out);
        end
        tests_run++;
        if (bus_if.bus_master_out !== 2'd0 || bus_if.bus_master_data_out !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_owner: got %0d/%0d expected 0/0", bus_if.bus_master_out, bus_if.bus_master_data_out);
        end
        tests_run++;
        if (bus_if.bus_mastlock_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mastlock: got %b expected 0", bus_if.bus_mastlock_out);
        end
    endtask

    task automatic test_single_master();
        do_reset();
        bus_if.master_req_in = 4'b0010;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0010 || bus_if.bus_master_out !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_grant: got grant %b owner %0d expected 0010 owner 0", bus_if.master_grant_out, bus_if.bus_master_out);
        end
        tick();
        tests_run++;
        if (bus_if.bus_master_out !== 2'd1 || bus_if.bus_master_data_out !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_owner: got %0d/%0d expected 1/0", bus_if.bus_master_out, bus_if.bus_master_data_out);
        end
        tick();
        tests_run++;
        if (bus_if.bus_master_data_out !== 2'd1 || bus_if.master_grant_out !== 4'b0010) begin
            tests_failed++;
            $display("FAIL single_data_owner: got data %0d grant %b expected 1 0010", bus_if.bus_master_data_out, bus_if.master_grant_out);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx[6] = '{2, 3, 0, 1, 2, 3};
        int prev;
        do_reset();
        bus_if.master_req_in = 4'b1111;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rr_first: got %b expected 0010", bus_if.master_grant_out);
        end
        prev = 1;
        bus_if.bus_trans_in = 2'b10;
        bus_if.bus_burst_in = 3'b000;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests_run++;
            if (bus_if.master_grant_out !== (4'b0001 << exp_idx[k]) || bus_if.bus_master_out !== 2'(prev)) begin
                tests_failed++;
                $display("FAIL rr_step%0d: got grant %b owner %0d expected grant %b owner %0d",
                         k, bus_if.master_grant_out, bus_if.bus_master_out, 4'b0001 << exp_idx[k], prev);
            end
            prev = exp_idx[k];
        end
    endtask

    task automatic test_burst_stall();
        do_reset();
        bus_if.master_req_in = 4'b0001;
        tick();
        bus_if.bus_trans_in = 2'b10;
        bus_if.bus_burst_in = 3'b011;
        tick();
        bus_if.bus_trans_in  = 2'b11;
        bus_if.master_req_in = 4'b1001;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL burst_beat2: got %b expected 0001", bus_if.master_grant_out);
        end
        bus_if.bus_ready_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests_run++;
            if (bus_if.master_grant_out !== 4'b0001) begin
                tests_failed++;
                $display("FAIL burst_stall%0d: got %b expected 0001", k, bus_if.master_grant_out);
            end
        end
        bus_if.bus_ready_in = 1'b1;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL burst_beat3: got %b expected 0001", bus_if.master_grant_out);
        end
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b1000) begin
            tests_failed++;
            $display("FAIL burst_beat4: got %b expected 1000", bus_if.master_grant_out);
        end
    endtask

    task automatic test_incr_drop();
        do_reset();
        bus_if.master_req_in = 4'b0100;
        tick();
        bus_if.bus_trans_in  = 2'b10;
        bus_if.bus_burst_in  = 3'b001;
        bus_if.master_req_in = 4'b0110;
        tick();
        bus_if.bus_trans_in = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if (bus_if.master_grant_out !== 4'b0100) begin
                tests_failed++;
                $display("FAIL incr_seq%0d: got %b expected 0100", k, bus_if.master_grant_out);
            end
        end
        bus_if.master_req_in = 4'b0010;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0010) begin
            tests_failed++;
            $display("FAIL incr_drop: got %b expected 0010", bus_if.master_grant_out);
        end
    endtask

    task automatic test_lock();
        do_reset();
        bus_if.master_req_in  = 4'b0010;
        bus_if.master_lock_in = 4'b0010;
        tick();
        bus_if.master_req_in = 4'b0011;
        bus_if.bus_trans_in  = 2'b10;
        bus_if.bus_burst_in  = 3'b000;
        tick();
`ifdef AHB_ARBITER_LOCK_EN
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (bus_if.master_grant_out !== 4'b0010 || bus_if.bus_mastlock_out !== 1'b1) begin
                tests_failed++;
                $display("FAIL lock_hold%0d: got grant %b lock %b expected 0010 1", k, bus_if.master_grant_out, bus_if.bus_mastlock_out);
            end
            tick();
        end
        bus_if.master_lock_in = 4'b0000;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL lock_release: got %b expected 0001", bus_if.master_grant_out);
        end
`else
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001 || bus_if.bus_mastlock_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL nolock_rotate: got grant %b lock %b expected 0001 0", bus_if.master_grant_out, bus_if.bus_mastlock_out);
        end
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0010 || bus_if.bus_mastlock_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL nolock_rotate2: got grant %b lock %b expected 0010 0", bus_if.master_grant_out, bus_if.bus_mastlock_out);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus_if.master_req_in = 4'b0100;
        tick();
        bus_if.bus_trans_in = 2'b10;
        bus_if.bus_burst_in = 3'b101;
        tick();
        bus_if.bus_trans_in = 2'b11;
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0100 || bus_if.bus_master_out !== 2'd2) begin
            tests_failed++;
            $display("FAIL midburst_pre: got grant %b owner %0d expected 0100 2", bus_if.master_grant_out, bus_if.bus_master_out);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001 || bus_if.bus_master_out !== 2'd0 ||
            bus_if.bus_master_data_out !== 2'd0 || bus_if.bus_mastlock_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midburst_reset: got grant %b owner %0d data %0d lock %b expected 0001 0 0 0",
                     bus_if.master_grant_out, bus_if.bus_master_out, bus_if.bus_master_data_out, bus_if.bus_mastlock_out);
        end
        do_reset();
        tick();
        tests_run++;
        if (bus_if.master_grant_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midburst_park: got %b expected 0001", bus_if.master_grant_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_round_robin();
        test_burst_stall();
        test_incr_drop();
        test_lock();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
